// File: rtl/bc_uart_tx_if.sv
// Breadcrumb FIFO read port as seen by the UART transmitter.
// The master is the reader (it issues the pop strobe). The slave is the FIFO.
interface bc_uart_tx_if;
  logic        fifo_empty;
  logic [15:0] fifo_dout;
  logic        fifo_rd_en;

  modport master (input  fifo_empty, input  fifo_dout, output fifo_rd_en);
  modport slave  (output fifo_empty, output fifo_dout, input  fifo_rd_en);
endinterface

// File: rtl/bc_uart_tx.sv
// Breadcrumb UART transmitter.
// Pops one 16-bit word from the breadcrumb FIFO and sends it as a 4-byte
// 8N1 frame: SYNC, HI, LO, CHK, where CHK = SYNC ^ HI ^ LO.
// All outputs come straight from flops.
module bc_uart_tx #(
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  bc_uart_tx_if.master        fifo,
  output logic                tx,
  output logic                busy,
  output logic                frame_done,
  output logic [15:0]         frame_count
);

  localparam int             CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  CNT_LAST = CW'(CLKS_PER_BIT - 1);
  // Bit slot inside a byte: 0 = start, 1..8 = d0..d7, 9 = stop.
  localparam logic [3:0]     BIT_STOP = 4'd9;
  localparam logic [1:0]     BYTE_CHK = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    POP   = 2'd1,
    LATCH = 2'd2,
    SEND  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     word_q, word_d;
  logic [7:0]      chk_q, chk_d;
  logic [1:0]      byte_idx_q, byte_idx_d;
  logic [3:0]      bit_idx_q, bit_idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            tx_q, tx_d;
  logic            rd_en_q, rd_en_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [15:0]     frame_count_q, frame_count_d;
  logic [7:0]      cur_byte;

  // Byte currently on the line, selected by byte index.
  always_comb begin
    cur_byte = SYNC_BYTE;
    unique case (byte_idx_q)
      2'd0:    cur_byte = SYNC_BYTE;
      2'd1:    cur_byte = word_q[15:8];
      2'd2:    cur_byte = word_q[7:0];
      default: cur_byte = chk_q;
    endcase
  end

  // Next-state and registered-output logic. tx_d is the level for the
  // next cycle, so a bit boundary loads the value of the following slot.
  always_comb begin
    state_d       = state_q;
    word_d        = word_q;
    chk_d         = chk_q;
    byte_idx_d    = byte_idx_q;
    bit_idx_d     = bit_idx_q;
    cnt_d         = cnt_q;
    tx_d          = tx_q;
    rd_en_d       = 1'b0;
    busy_d        = busy_q;
    done_d        = 1'b0;
    frame_count_d = frame_count_q;

    unique case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (enable && !fifo.fifo_empty) begin
          state_d = POP;
          rd_en_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      POP: begin
        // FIFO presents the popped word during the next cycle.
        state_d = LATCH;
      end
      LATCH: begin
        word_d     = fifo.fifo_dout;
        chk_d      = SYNC_BYTE ^ fifo.fifo_dout[15:8] ^ fifo.fifo_dout[7:0];
        byte_idx_d = 2'd0;
        bit_idx_d  = 4'd0;
        cnt_d      = '0;
        tx_d       = 1'b0;
        state_d    = SEND;
      end
      SEND: begin
        if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          if (bit_idx_q == BIT_STOP) begin
            if (byte_idx_q == BYTE_CHK) begin
              state_d       = IDLE;
              done_d        = 1'b1;
              busy_d        = 1'b0;
              tx_d          = 1'b1;
              frame_count_d = frame_count_q + 16'd1;
            end else begin
              // Next start bit follows the stop bit with no gap.
              byte_idx_d = byte_idx_q + 2'd1;
              bit_idx_d  = 4'd0;
              tx_d       = 1'b0;
            end
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
            tx_d      = (bit_idx_q == 4'd8) ? 1'b1 : cur_byte[bit_idx_q[2:0]];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers. Reset aborts any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      word_q        <= '0;
      chk_q         <= '0;
      byte_idx_q    <= '0;
      bit_idx_q     <= '0;
      cnt_q         <= '0;
      tx_q          <= 1'b1;
      rd_en_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      word_q        <= word_d;
      chk_q         <= chk_d;
      byte_idx_q    <= byte_idx_d;
      bit_idx_q     <= bit_idx_d;
      cnt_q         <= cnt_d;
      tx_q          <= tx_d;
      rd_en_q       <= rd_en_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign fifo.fifo_rd_en = rd_en_q;
  assign tx              = tx_q;
  assign busy            = busy_q;
  assign frame_done      = done_q;
  assign frame_count     = frame_count_q;

endmodule

// File: tb/tb_bc_uart_tx.sv
// Bench for bc_uart_tx: queue-based FIFO model, free-running UART decoder,
// and frames compared against {SYNC, HI, LO, SYNC^HI^LO}.
module tb_bc_uart_tx;
  localparam int         C    = 4;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         FRAME_CYC = 40 * C;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        tx, busy, frame_done;
  logic [15:0] frame_count;

  bc_uart_tx_if fifo_if ();

  bc_uart_tx #(.CLKS_PER_BIT(C), .SYNC_BYTE(SYNC)) dut (
    .clk(clk), .rst(rst), .enable(enable), .fifo(fifo_if.master),
    .tx(tx), .busy(busy), .frame_done(frame_done), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;

  // FIFO model: data appears the cycle after a pop, junk otherwise.
  logic [15:0] fifo_q[$];
  assign fifo_if.fifo_empty = (fifo_q.size() == 0);
  always @(posedge clk) begin
    if (fifo_if.fifo_rd_en && fifo_q.size() > 0) fifo_if.fifo_dout <= fifo_q.pop_front();
    else                                         fifo_if.fifo_dout <= 16'($urandom);
  end

  // Monitors and UART decoder, sampling at the falling edge.
  int cyc = 0, pops = 0, dones = 0, busy_cyc = 0, empty_rd_viol = 0, last_pop_cyc = 0;
  logic [7:0] rx_b[0:255];
  int         rx_t[0:255];
  int         rx_n = 0, rx_bad = 0;
  bit         act = 1'b0;
  int         rcnt = 0, st = 0, rk = 0;
  logic [7:0] sh = 8'h00;

  always @(negedge clk) begin
    cyc++;
    if (fifo_if.fifo_rd_en === 1'b1) begin
      pops++;
      last_pop_cyc = cyc;
      if (fifo_if.fifo_empty) empty_rd_viol++;
    end
    if (frame_done === 1'b1) dones++;
    if (busy === 1'b1) busy_cyc++;
    if (rst) act = 1'b0;
    else if (!act) begin
      if (tx === 1'b0) begin act = 1'b1; rcnt = 0; st = cyc; end
    end else begin
      rcnt++;
      if (rcnt % C == C / 2) begin
        rk = rcnt / C;
        if (rk == 0) begin
          if (tx !== 1'b0) rx_bad++;
        end else if (rk <= 8) sh[rk-1] = tx;
        else begin
          if (tx !== 1'b1) rx_bad++;
          if (rx_n < 256) begin rx_b[rx_n] = sh; rx_t[rx_n] = st; rx_n++; end
          act = 1'b0;
        end
      end
    end
  end
  // The start-bit sample happens at rcnt == C/2 only if detection sets rcnt=0.
  // (rk==0 branch is reached because rcnt is incremented before the test.)

  function automatic logic [31:0] frame_of(input logic [15:0] w);
    logic [7:0] hi, lo;
    hi = w[15:8];
    lo = w[7:0];
    return {SYNC, hi, lo, SYNC ^ hi ^ lo};
  endfunction

  function automatic logic [31:0] rx_frame(input int i);
    if (i < 0 || i + 3 > 255) return 32'hxxxxxxxx;
    return {rx_b[i], rx_b[i+1], rx_b[i+2], rx_b[i+3]};
  endfunction

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin @(negedge clk); #1; end
  endtask

  task automatic wait_dones(input int target, input int limit, output bit ok);
    int n = 0;
    while (dones < target && n < limit) begin @(negedge clk); #1; n++; end
    ok = (dones >= target);
  endtask

  task automatic test_reset;
    int bad = 0, p0;
    rst = 1'b1; enable = 1'b1;
    #2;
    n_tests++;
    if ({tx, fifo_if.fifo_rd_en, busy, frame_done, frame_count} !== {4'b1000, 16'h0000}) begin
      n_fail++;
      $display("FAIL reset_values: got tx=%b rd=%b busy=%b done=%b cnt=%h, want 1 0 0 0 0000",
               tx, fifo_if.fifo_rd_en, busy, frame_done, frame_count);
    end
    tick(3);
    @(negedge clk); rst = 1'b0; exp_cnt = 0;
    p0 = pops;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (tx !== 1'b1 || fifo_if.fifo_rd_en !== 1'b0 || busy !== 1'b0 || frame_count !== 16'h0) bad++;
    end
    n_tests++;
    if (bad != 0 || pops != p0) begin
      n_fail++;
      $display("FAIL idle_empty: bad cycles %0d pops %0d, want 0 0", bad, pops - p0);
    end
  endtask

  task automatic test_single;
    int p0 = pops, d0 = dones, b0 = busy_cyc, r0 = rx_n;
    bit ok;
    @(negedge clk); fifo_q.push_back(16'h1234);
    wait_dones(d0 + 1, 400, ok);
    exp_cnt++;
    tick(20);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL single_timeout: no frame_done, want 1 pulse"); end
    n_tests++;
    if (pops - p0 != 1) begin n_fail++; $display("FAIL single_pops: got %0d want 1", pops - p0); end
    n_tests++;
    if (rx_n - r0 != 4 || rx_frame(r0) !== 32'hA5123483) begin
      n_fail++;
      $display("FAIL single_bytes: got %h (%0d bytes) want a5123483", rx_frame(r0), rx_n - r0);
    end
    n_tests++;
    if (rx_t[r0] - last_pop_cyc != 2) begin
      n_fail++; $display("FAIL single_latency: got %0d want 2", rx_t[r0] - last_pop_cyc);
    end
    n_tests++;
    if (dones - d0 != 1 || frame_count !== 16'(exp_cnt)) begin
      n_fail++;
      $display("FAIL single_done: pulses %0d cnt %h, want 1 %h", dones - d0, frame_count, 16'(exp_cnt));
    end
    // Busy spans the pop cycle, the latch cycle and the 40 bit periods.
    n_tests++;
    if (busy_cyc - b0 != FRAME_CYC + 2 || busy !== 1'b0) begin
      n_fail++; $display("FAIL single_busy: got %0d want %0d", busy_cyc - b0, FRAME_CYC + 2);
    end
  endtask

  task automatic test_back_to_back;
    int p0 = pops, d0 = dones, r0 = rx_n;
    bit ok;
    @(negedge clk); fifo_q.push_back(16'h0000); fifo_q.push_back(16'hFFFF);
    wait_dones(d0 + 2, 800, ok);
    exp_cnt += 2;
    tick(20);
    n_tests++;
    if (!ok || rx_n - r0 != 8) begin
      n_fail++; $display("FAIL b2b_count: got %0d bytes want 8", rx_n - r0);
    end
    n_tests++;
    if (rx_frame(r0) !== 32'hA50000A5 || rx_frame(r0 + 4) !== 32'hA5FFFFA5) begin
      n_fail++;
      $display("FAIL b2b_bytes: got %h %h want a50000a5 a5ffffa5", rx_frame(r0), rx_frame(r0 + 4));
    end
    // Start-to-start: 40 bit periods, then one IDLE cycle (done pulse),
    // then the POP and LATCH cycles before the next start bit.
    n_tests++;
    if (rx_t[r0 + 4] - rx_t[r0] != FRAME_CYC + 3) begin
      n_fail++; $display("FAIL b2b_spacing: got %0d want %0d", rx_t[r0 + 4] - rx_t[r0], FRAME_CYC + 3);
    end
    n_tests++;
    if (pops - p0 != 2 || frame_count !== 16'(exp_cnt)) begin
      n_fail++; $display("FAIL b2b_pops: pops %0d cnt %h want 2 %h", pops - p0, frame_count, 16'(exp_cnt));
    end
  endtask

  task automatic test_random;
    logic [15:0] w[6];
    int d0 = dones, r0 = rx_n;
    bit ok;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin w[i] = 16'($urandom); fifo_q.push_back(w[i]); end
    wait_dones(d0 + 6, 6 * 200, ok);
    exp_cnt += 6;
    tick(20);
    n_tests++;
    if (!ok || rx_n - r0 != 24) begin
      n_fail++; $display("FAIL rand_count: got %0d bytes want 24", rx_n - r0);
    end
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if (rx_frame(r0 + 4 * i) !== frame_of(w[i])) begin
        n_fail++; $display("FAIL rand_frame%0d: got %h want %h", i, rx_frame(r0 + 4 * i), frame_of(w[i]));
      end
    end
  endtask

  task automatic test_enable;
    logic [15:0] w[3];
    int p0 = pops, d0 = dones, r0 = rx_n, n = 0;
    bit ok;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin w[i] = 16'($urandom); fifo_q.push_back(w[i]); end
    while (rx_n <= r0 && n < 200) begin tick(1); n++; end
    tick(2);
    enable = 1'b0;  // now inside the HI byte
    wait_dones(d0 + 1, 400, ok);
    exp_cnt++;
    tick(3 * FRAME_CYC);
    n_tests++;
    if (!ok || rx_n - r0 != 4 || rx_frame(r0) !== frame_of(w[0])) begin
      n_fail++; $display("FAIL en_finish: got %h want %h", rx_frame(r0), frame_of(w[0]));
    end
    n_tests++;
    if (pops - p0 != 1 || dones - d0 != 1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL en_gated: pops %0d dones %0d want 1 1", pops - p0, dones - d0);
    end
    enable = 1'b1;
    wait_dones(d0 + 3, 800, ok);
    exp_cnt += 2;
    tick(20);
    n_tests++;
    if (!ok || rx_frame(r0 + 4) !== frame_of(w[1]) || rx_frame(r0 + 8) !== frame_of(w[2])) begin
      n_fail++;
      $display("FAIL en_resume: got %h %h want %h %h", rx_frame(r0 + 4), rx_frame(r0 + 8),
               frame_of(w[1]), frame_of(w[2]));
    end
    n_tests++;
    if (pops - p0 != 3 || frame_count !== 16'(exp_cnt)) begin
      n_fail++; $display("FAIL en_count: pops %0d cnt %h want 3 %h", pops - p0, frame_count, 16'(exp_cnt));
    end
  endtask

  task automatic test_async_reset;
    logic [15:0] wa, wb;
    int d0 = dones, r0 = rx_n, r1, p1, n = 0;
    bit ok;
    wa = 16'($urandom); wb = ~wa;
    @(negedge clk); fifo_q.push_back(wa); fifo_q.push_back(wb);
    while (rx_n <= r0 && n < 200) begin tick(1); n++; end
    tick(2 * C + 2);  // inside HI data bits
    @(posedge clk); #2; rst = 1'b1; #1;
    n_tests++;
    if (tx !== 1'b1 || busy !== 1'b0 || frame_count !== 16'h0) begin
      n_fail++; $display("FAIL rst_async: tx %b busy %b cnt %h want 1 0 0000", tx, busy, frame_count);
    end
    exp_cnt = 0;
    tick(3);
    @(negedge clk); rst = 1'b0;
    r1 = rx_n; p1 = pops;
    wait_dones(d0 + 1, 400, ok);
    exp_cnt++;
    tick(3 * FRAME_CYC);
    n_tests++;
    if (!ok || rx_n - r1 != 4 || rx_frame(r1) !== frame_of(wb)) begin
      n_fail++; $display("FAIL rst_next: got %h (%0d bytes) want %h", rx_frame(r1), rx_n - r1, frame_of(wb));
    end
    n_tests++;
    if (pops - p1 != 1 || dones - d0 != 1 || frame_count !== 16'(exp_cnt) || fifo_q.size() != 0) begin
      n_fail++;
      $display("FAIL rst_discard: pops %0d dones %0d cnt %h want 1 1 %h", pops - p1, dones - d0,
               frame_count, 16'(exp_cnt));
    end
  endtask

  task automatic test_wrap;
    logic [15:0] w;
    int d0 = dones, r0 = rx_n;
    bit ok;
    w = 16'($urandom);
    @(negedge clk);
    force dut.frame_count_q = 16'hFFFF;
    #1 release dut.frame_count_q;
    tick(2);
    fifo_q.push_back(w);
    wait_dones(d0 + 1, 400, ok);
    tick(20);
    n_tests++;
    if (!ok || frame_count !== 16'h0000 || dones - d0 != 1) begin
      n_fail++; $display("FAIL wrap_count: got %h want 0000", frame_count);
    end
    n_tests++;
    if (rx_frame(r0) !== frame_of(w)) begin
      n_fail++; $display("FAIL wrap_frame: got %h want %h", rx_frame(r0), frame_of(w));
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_random();
    test_enable();
    test_async_reset();
    test_wrap();
    n_tests++;
    if (empty_rd_viol != 0 || rx_bad != 0) begin
      n_fail++; $display("FAIL protocol: rd_en-while-empty %0d framing errors %0d want 0 0", empty_rd_viol, rx_bad);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
